// File: rtl/perf_event_counter.sv
// Performance counters (cycles, instructions, I/D-cache requests and hits) with a latency-1 read port.
// Optional macro PERF_SNAPSHOT_EN adds a snap input and shadow registers that reads return instead.
module perf_event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
`ifdef PERF_SNAPSHOT_EN
  input  logic             snap,
`endif
  input  logic             rd_en,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             running,
  output logic             halted,
  output logic             err_hit_no_req
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam int         NCNT      = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]                 state_q, state_d;
  logic                       running_q, running_d;
  logic                       halted_q, halted_d;
  logic                       err_q, err_d;
  logic [NCNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCNT-1:0][CNT_W-1:0] rd_src;
  logic [NCNT-1:0]            inc;
  logic [CNT_W-1:0]           rd_data_q, rd_data_d, rd_mux;
  logic                       rd_valid_q;
  logic                       count_en;
  logic                       hit_no_req;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) return v + CNT_W'(1);
    return v;
  endfunction

  // Hits only count when paired with their request; an orphan hit flags an error instead.
  assign hit_no_req = (icache_hit & ~icache_req) | (dcache_hit & ~dcache_req);
  assign count_en   = (state_q == ST_RUN) & ~clr;

  assign inc[0] = 1'b1;
  assign inc[1] = halt | reg_write | mem_write;
  assign inc[2] = icache_req;
  assign inc[3] = icache_hit & icache_req;
  assign inc[4] = dcache_req;
  assign inc[5] = dcache_hit & dcache_req;

  always_comb begin
    state_d = state_q;
    err_d   = err_q | hit_no_req;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = sat_inc(cnt_q[i], count_en & inc[i]);
    end
    if (clr) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_RUN;
        ST_RUN:    if (halt) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALTED);
  end

`ifdef PERF_SNAPSHOT_EN
  logic [NCNT-1:0][CNT_W-1:0] shadow_q, shadow_d;

  // The RUN->HALTED snapshot captures the counts including the halt cycle itself.
  always_comb begin
    shadow_d = shadow_q;
    if (clr) shadow_d = '0;
    else if (snap || ((state_q == ST_RUN) && halt)) shadow_d = cnt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) shadow_q <= '0;
    else      shadow_q <= shadow_d;
  end

  assign rd_src = shadow_q;
`else
  assign rd_src = cnt_q;
`endif

  // Reads sample the pre-update counter values, so a read alongside clr sees the old count.
  always_comb begin
    case (rd_sel)
      3'd0:    rd_mux = rd_src[0];
      3'd1:    rd_mux = rd_src[1];
      3'd2:    rd_mux = rd_src[2];
      3'd3:    rd_mux = rd_src[3];
      3'd4:    rd_mux = rd_src[4];
      3'd5:    rd_mux = rd_src[5];
      3'd6:    rd_mux = {{(CNT_W-3){1'b0}}, err_q, halted_q, running_q};
      default: rd_mux = '0;
    endcase
    rd_data_d = rd_en ? rd_mux : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign running        = running_q;
  assign halted         = halted_q;
  assign err_hit_no_req = err_q;

endmodule

// File: doc/perf_event_counter.md
Name: perf_event_counter

Overview:
- Hardware performance-counter block sitting directly downstream of the processor's commit/WB point and cache interfaces.
- Consumes per-cycle retire signals (register write, memory write, halt) and the I-cache/D-cache request and hit strobes.
- Accumulates cycle, instruction, and cache statistics in hardware. A simple registered read port exposes them to a debug/host reader.
- Stops on halt, so the final counts match the processor's halted state.

Parameters:
- CNT_W, 32, width of every event counter (valid range 8..32).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins counting (IDLE -> RUN).
- clr  in  1  one-cycle pulse; zeroes counters, returns to IDLE.
- reg_write  in  1  retiring instruction writes register file this cycle.
- mem_write  in  1  retiring instruction writes memory this cycle.
- halt  in  1  halt instruction retiring this cycle.
- icache_req  in  1  valid I-cache request this cycle.
- icache_hit  in  1  I-cache hit this cycle.
- dcache_req  in  1  valid D-cache read/write request this cycle.
- dcache_hit  in  1  D-cache hit this cycle.
- rd_en  in  1  read request.
- rd_sel  in  3  counter select.
- rd_data  out  CNT_W  registered read data.
- rd_valid  out  1  rd_data valid.
- running  out  1  high in RUN state.
- halted  out  1  high in HALTED state.
- err_hit_no_req  out  1  sticky: a hit was seen without its matching req.

Behaviour:
- Reset (rst low, async): state IDLE; all counters 0; rd_data 0; rd_valid 0; running 0; halted 0; err_hit_no_req 0.

State machine (IDLE, RUN, HALTED):
- IDLE: start -> RUN. No counting.
- RUN: counting enabled. halt -> HALTED at the next edge.
- HALTED: counters frozen. start is ignored. Only clr or reset leaves this state.
- clr has priority over start and halt in every state: counters zero, err flag cleared, next state IDLE.
- running = (state == RUN); halted = (state == HALTED). Both are registered.

Counting (RUN state only, including the halt cycle itself):
- cycle_cnt: +1 every cycle.
- inst_cnt: +1 when (halt | reg_write | mem_write). Max +1 per cycle.
- icreq_cnt: +1 on icache_req.
- ichit_cnt: +1 on (icache_hit & icache_req).
- dcreq_cnt / dchit_cnt: same rule using the D-cache strobes.
- Any hit without its req, in any state, sets err_hit_no_req. That hit is not counted.
- All counters saturate at all-ones (2^CNT_W - 1). They never wrap.

Read port:
- rd_en sampled at edge N; rd_data/rd_valid presented at N+1. Latency 1, one read per cycle, back-to-back allowed.
- rd_valid = registered rd_en. rd_data holds its last value when rd_valid is 0.
- Read returns the counter value at edge N, before that cycle's increment.
- rd_sel: 0 cycle, 1 inst, 2 icreq, 3 ichit, 4 dcreq, 5 dchit, 6 status {zero-pad, err_hit_no_req, halted, running}, 7 reads 0.
- Read with simultaneous clr returns the pre-clear value.

Reset mid-operation: immediate asynchronous return to the reset values above. In-flight reads are dropped (rd_valid 0).

Optional Feature:
- Macro: PERF_SNAPSHOT_EN.
- Defined:
  - Adds input snap (1 bit).
  - snap at edge N copies all six counters into shadow registers atomically. Snap also occurs automatically on the RUN->HALTED transition.
  - rd_sel 0..5 then return shadow values, not live counters.
  - Shadows reset to 0 and are cleared by clr.
- Not defined: no snap port, no shadow registers; reads return live counters.

Test Plan:
- Reset, start, 10 cycles of RUN with reg_write high on 4 of them, then halt pulse -> cycle_cnt=11, inst_cnt=5, halted=1, running=0; counts unchanged 20 cycles later.
- RUN with icache_req on 8 cycles and icache_hit on 6 of those; dcache_hit pulsed once without dcache_req -> icreq=8, ichit=6, dchit=0, err_hit_no_req=1, status read = 0x4 | running.
- CNT_W=8, RUN for 300 cycles -> cycle_cnt reads 0xFF (saturated, not 0x2C).
- Back-to-back reads sel 0,1,7 on consecutive cycles during RUN -> rd_valid high 3 cycles; third rd_data=0; first value equals the cycle count at the sampling edge.
- clr and start asserted the same cycle while HALTED -> state IDLE, all counters 0, no counting next cycle; a later start alone -> RUN.
- rst driven low asynchronously mid-cycle during RUN with rd_en high -> outputs go to 0 immediately without a clock edge; rd_valid 0 after release.
